// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The pow10 helper is used at elaboration to check that D digits can hold every input value.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIG_W = 4;
  localparam logic [DIG_W-1:0] ADJ_UMBRAL = 4'd5;
  localparam logic [DIG_W-1:0] ADJ_SUMA   = 4'd3;

  function automatic longint unsigned pow10(input int d);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_ajuste_digito.sv
// Double-dabble digit correction applied before each shift.
// Adds 3 to a 4-bit BCD digit that is 5 or greater.
module bcd_ajuste_digito
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] digito,
  output logic [DIG_W-1:0] ajustado
);

  assign ajustado = (digito >= ADJ_UMBRAL) ? digito + ADJ_SUMA : digito;

endmodule

// File: rtl/bin_a_bcd_secuencial.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// bcd is registered and changes only on the edge that enters DONE.
module bin_a_bcd_secuencial
  import bcd_pkg::*;
#(
  parameter int N = 4,
  parameter int D = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     bin,
  input  logic             start,
  output logic [4*D-1:0]   bcd,
  output logic [3:0]       unidades,
  output logic [3:0]       decenas,
  output logic             busy,
  output logic             done
);

  localparam int SR_W  = DIG_W * D + N;
  localparam int CNT_W = $clog2(N + 1);

  if (pow10(D) <= (64'd1 << N) - 64'd1) begin : g_d_insuficiente
    $error("bin_a_bcd_secuencial: D=%0d digits cannot represent 2^%0d-1", D, N);
  end

  state_t           state, state_next;
  logic [SR_W-1:0]  shreg;
  logic [SR_W-1:0]  adj;
  logic [SR_W-1:0]  shifted;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             shift;
  logic             fin;

  // Every digit of the BCD field, including the top one, is corrected before the shift.
  for (genvar i = 0; i < D; i++) begin : g_dig
    bcd_ajuste_digito u_ajuste (
      .digito   (shreg[N + DIG_W*i +: DIG_W]),
      .ajustado (adj[N + DIG_W*i +: DIG_W])
    );
  end

  assign adj[N-1:0] = shreg[N-1:0];
  assign shifted    = adj << 1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    fin        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (cnt == CNT_W'(1)) begin
          fin        = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = CONV;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The result register is loaded from the post-shift value so it is valid in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      bcd   <= '0;
    end else if (load) begin
      shreg <= {{(DIG_W*D){1'b0}}, bin};
      cnt   <= CNT_W'(N);
    end else if (shift) begin
      shreg <= shifted;
      cnt   <= cnt - CNT_W'(1);
      if (fin) bcd <= shifted[SR_W-1:N];
    end
  end

  assign unidades = bcd[3:0];

  if (D >= 2) begin : g_decenas
    assign decenas = bcd[7:4];
  end else begin : g_sin_decenas
    assign decenas = 4'd0;
  end

endmodule

// File: doc/bin_a_bcd_secuencial.md
Name: bin_a_bcd_secuencial

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
- Sits between the Gray-to-binary decoder (source of `bin`) and the seven-segment driver (consumer of `unidades`/`decenas`).
- Start/done handshake; the result is registered and held stable between conversions so the display never sees intermediate values.

Parameters:
- N, 4, binary input width (bits).
- D, 2, number of BCD output digits. Elaboration error if 10^D <= 2^N - 1, i.e. if D digits cannot represent the maximum input.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- bin  input  N  binary value to convert; sampled only on the accept edge.
- start  input  1  request conversion; level-sampled.
- bcd  output  4*D  registered result, digit i at bcd[4i+3:4i].
- unidades  output  4  alias of bcd[3:0].
- decenas  output  4  alias of bcd[7:4].
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd updates.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `rst`. While `rst` is high at a rising edge:
  - state=IDLE, bcd=0, busy=0, done=0;
  - shift register and bit counter cleared.
- States: IDLE, CONV, DONE (encoding from the package).
- IDLE:
  - start=1 at edge k: load shift register {D*4 zeros, bin}, counter=N, go to CONV.
  - start=0: stay.
- CONV, one bit per cycle:
  - Apply per-digit correction (digit>=5 -> digit+3, 4-bit result), then shift the whole register left by 1.
  - Decrement counter.
  - When the counter reaches 1 on that edge (last shift), go to DONE.
  - Exactly N shift edges are spent in CONV.
- DONE, one cycle:
  - bcd loaded from the BCD field of the shift register on the edge entering DONE, so the new bcd is visible in the same cycle done=1.
  - done=1 for exactly this cycle; busy=0.
  - start=1 here is accepted exactly as in IDLE (back-to-back throughput = N+1 cycles); otherwise go to IDLE.
- Latency: start accepted at edge k -> busy=1 cycles k+1..k+N -> done=1 and bcd valid in cycle k+N+1.
- Hold and ignore rules:
  - bcd holds its value at all times except the DONE-entry edge.
  - start while in CONV is ignored (no queueing).
  - bin changes after the accept edge have no effect.
- Reset mid-conversion: aborts, no done pulse, bcd returns to 0.
- Width rules:
  - Correction applies to every digit, including the top one, before each shift.
  - The shift register is 4*D+N bits; the bits shifted out of the top are discarded. They are always zero given the D constraint.
- busy and done are never high simultaneously.

Decomposition:
- Package bcd_pkg:
  - state typedef/localparams (IDLE, CONV, DONE);
  - DIG_W=4;
  - ADJ_UMBRAL=5;
  - ADJ_SUMA=3.
- Sub-module bcd_ajuste_digito:
  - combinational, 4-bit in / 4-bit out, add 3 if >=5;
  - instantiated D times with a generate loop over the BCD field.
- FSM, counter and output registers stay in the top module.

Test Plan:
- rst, then bin=4'b1111, start pulse at edge k:
  - busy=1 for cycles k+1..k+4;
  - done=1 only at k+5 with bcd=8'h15 (decenas=1, unidades=5).
- Exhaustive sweep, N=4: bin=0..15 back-to-back, start held high.
  - Each done reports the correct BCD (e.g. 9 -> 8'h09, 10 -> 8'h10).
  - done is spaced exactly 5 cycles apart.
- start pulses and bin changes during CONV:
  - ignored; single done with the originally sampled value;
  - bcd unchanged until that done.
- rst asserted at cycle k+2 of a conversion of bin=12:
  - next cycle bcd=0, busy=0, done never pulses;
  - a new start with bin=7 gives bcd=8'h07.
- N=8, D=3: bin=255 -> bcd=12'h255 at k+9; bin=100 -> 12'h100; bin=0 -> 12'h000.
